// File: rtl/sram_responder_pkg.sv
// Shared widths, FSM encoding and request decode for the SSRAM responder.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package sram_responder_pkg;

    localparam int SRAM_ADDR_WIDTH  = 19;
    localparam int SRAM_DATA_WIDTH  = 32;
    localparam int SRAM_MASK_WIDTH  = SRAM_DATA_WIDTH / 8;
    localparam int SRAM_INIT_CYCLES = 16;

    typedef enum logic [0:0] {
        ST_INIT = 1'b0,
        ST_RUN  = 1'b1
    } state_e;

    // An all-zero byte mask marks the request as a read.
    function automatic logic is_read(input logic [SRAM_MASK_WIDTH-1:0] mask);
        return (mask == '0);
    endfunction

endpackage

// File: rtl/sram_pipe_stage.sv
// One in-flight slot {valid, is_write, data} of the SSRAM data pipeline.
// Latency: 1 cycle.
// Backpressure: none; advances every cycle, cleared by reset.
module sram_pipe_stage #(
    parameter int DATA_WIDTH = 32
) (
    input  logic                  clk_i,
    input  logic                  rst_ni,
    input  logic                  vld_i,
    input  logic                  wr_i,
    input  logic [DATA_WIDTH-1:0] dat_i,
    output logic                  vld_o,
    output logic                  wr_o,
    output logic [DATA_WIDTH-1:0] dat_o
);

    logic                  vld_q;
    logic                  wr_q;
    logic [DATA_WIDTH-1:0] dat_q;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            vld_q <= 1'b0;
            wr_q  <= 1'b0;
            dat_q <= '0;
        end else begin
            vld_q <= vld_i;
            wr_q  <= wr_i;
            dat_q <= dat_i;
        end
    end

    assign vld_o = vld_q;
    assign wr_o  = wr_q;
    assign dat_o = dat_q;

endmodule

// File: rtl/sram_responder.sv
// Accepts arbiter requests and drives a pipelined ZBT SSRAM; reads return in order.
// Latency: command pins 1 cycle after accept, write data at +3, read data strobe at +4.
// Backpressure: sram_ready low only during post-reset INIT, then one request per cycle.
module sram_responder
    import sram_responder_pkg::*;
#(
    parameter int ADDR_WIDTH  = SRAM_ADDR_WIDTH,
    parameter int DATA_WIDTH  = SRAM_DATA_WIDTH,
    parameter int MASK_WIDTH  = SRAM_MASK_WIDTH,
    parameter int INIT_CYCLES = SRAM_INIT_CYCLES
) (
    input  logic                  sram_clock,
    input  logic                  reset_n,
    input  logic                  sram_addr_valid,
    output logic                  sram_ready,
    input  logic [ADDR_WIDTH-1:0] sram_addr,
    input  logic [DATA_WIDTH-1:0] sram_data_in,
    input  logic [MASK_WIDTH-1:0] sram_write_mask,
    output logic [DATA_WIDTH-1:0] sram_data_out,
    output logic                  sram_data_out_valid,
    output logic                  ssram_ce_b,
    output logic                  ssram_adv_ld_b,
    output logic                  ssram_we_b,
    output logic [MASK_WIDTH-1:0] ssram_bw_b,
    output logic [ADDR_WIDTH-1:0] ssram_addr,
    output logic [DATA_WIDTH-1:0] ssram_dq_out,
    output logic                  ssram_dq_oe,
    input  logic [DATA_WIDTH-1:0] ssram_dq_in
);

    localparam int CNT_W = $clog2(INIT_CYCLES + 1);

    state_e               state_q;
    logic [CNT_W-1:0]     cnt_q;
    logic                 ready_q;

    logic                 accept;
    logic                 req_wr;

    assign accept = sram_addr_valid & ready_q;
    assign req_wr = ~is_read(sram_write_mask);

    always_ff @(posedge sram_clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= ST_INIT;
            cnt_q   <= CNT_W'(INIT_CYCLES - 1);
            ready_q <= 1'b0;
        end else begin
            case (state_q)
                ST_INIT: begin
                    if (cnt_q == '0) begin
                        state_q <= ST_RUN;
                        ready_q <= 1'b1;
                    end else begin
                        cnt_q <= cnt_q - 1'b1;
                    end
                end
                ST_RUN: ready_q <= 1'b1;
            endcase
        end
    end

    assign sram_ready = ready_q;

    logic                  ce_b_q;
    logic                  adv_ld_b_q;
    logic                  we_b_q;
    logic [MASK_WIDTH-1:0] bw_b_q;
    logic [ADDR_WIDTH-1:0] addr_q;

    // Address is held across idle cycles so the pins do not toggle needlessly.
    always_ff @(posedge sram_clock or negedge reset_n) begin
        if (!reset_n) begin
            ce_b_q     <= 1'b1;
            adv_ld_b_q <= 1'b1;
            we_b_q     <= 1'b1;
            bw_b_q     <= '1;
            addr_q     <= '0;
        end else begin
            ce_b_q     <= ~accept;
            adv_ld_b_q <= 1'b0;
            we_b_q     <= ~(accept & req_wr);
            bw_b_q     <= (accept & req_wr) ? ~sram_write_mask : '1;
            if (accept) begin
                addr_q <= sram_addr;
            end
        end
    end

    assign ssram_ce_b     = ce_b_q;
    assign ssram_adv_ld_b = adv_ld_b_q;
    assign ssram_we_b     = we_b_q;
    assign ssram_bw_b     = bw_b_q;
    assign ssram_addr     = addr_q;

    logic [2:0]            p_vld;
    logic [2:0]            p_wr;
    logic [DATA_WIDTH-1:0] p_dat [0:2];

    sram_pipe_stage #(.DATA_WIDTH(DATA_WIDTH)) u_stage0 (
        .clk_i  (sram_clock),
        .rst_ni (reset_n),
        .vld_i  (accept),
        .wr_i   (req_wr),
        .dat_i  (sram_data_in),
        .vld_o  (p_vld[0]),
        .wr_o   (p_wr[0]),
        .dat_o  (p_dat[0])
    );

    sram_pipe_stage #(.DATA_WIDTH(DATA_WIDTH)) u_stage1 (
        .clk_i  (sram_clock),
        .rst_ni (reset_n),
        .vld_i  (p_vld[0]),
        .wr_i   (p_wr[0]),
        .dat_i  (p_dat[0]),
        .vld_o  (p_vld[1]),
        .wr_o   (p_wr[1]),
        .dat_o  (p_dat[1])
    );

    sram_pipe_stage #(.DATA_WIDTH(DATA_WIDTH)) u_stage2 (
        .clk_i  (sram_clock),
        .rst_ni (reset_n),
        .vld_i  (p_vld[1]),
        .wr_i   (p_wr[1]),
        .dat_i  (p_dat[1]),
        .vld_o  (p_vld[2]),
        .wr_o   (p_wr[2]),
        .dat_o  (p_dat[2])
    );

    // The last slot lines up with the ZBT data phase two cycles after the command.
    assign ssram_dq_out = p_dat[2];
    assign ssram_dq_oe  = p_vld[2] & p_wr[2];

    logic                  rd_vld_q;
    logic [DATA_WIDTH-1:0] rd_dat_q;

    always_ff @(posedge sram_clock or negedge reset_n) begin
        if (!reset_n) begin
            rd_vld_q <= 1'b0;
            rd_dat_q <= '0;
        end else begin
            rd_vld_q <= p_vld[2] & ~p_wr[2];
            if (p_vld[2] & ~p_wr[2]) begin
                rd_dat_q <= ssram_dq_in;
            end
        end
    end

    assign sram_data_out       = rd_dat_q;
    assign sram_data_out_valid = rd_vld_q;

endmodule

// File: tb/tb_sram_responder.sv
// Directed bench for sram_responder with a small ZBT SSRAM model.
// Reads from unwritten words return addr+0x100.
module tb_sram_responder;

    logic        sram_clock = 1'b0;
    logic        reset_n = 1'b0;
    logic        sram_addr_valid = 1'b0;
    logic        sram_ready;
    logic [18:0] sram_addr = '0;
    logic [31:0] sram_data_in = '0;
    logic [3:0]  sram_write_mask = '0;
    logic [31:0] sram_data_out;
    logic        sram_data_out_valid;
    logic        ssram_ce_b, ssram_adv_ld_b, ssram_we_b;
    logic [3:0]  ssram_bw_b;
    logic [18:0] ssram_addr;
    logic [31:0] ssram_dq_out;
    logic        ssram_dq_oe;
    logic [31:0] ssram_dq_in;

    sram_responder dut (
        .sram_clock          (sram_clock),
        .reset_n             (reset_n),
        .sram_addr_valid     (sram_addr_valid),
        .sram_ready          (sram_ready),
        .sram_addr           (sram_addr),
        .sram_data_in        (sram_data_in),
        .sram_write_mask     (sram_write_mask),
        .sram_data_out       (sram_data_out),
        .sram_data_out_valid (sram_data_out_valid),
        .ssram_ce_b          (ssram_ce_b),
        .ssram_adv_ld_b      (ssram_adv_ld_b),
        .ssram_we_b          (ssram_we_b),
        .ssram_bw_b          (ssram_bw_b),
        .ssram_addr          (ssram_addr),
        .ssram_dq_out        (ssram_dq_out),
        .ssram_dq_oe         (ssram_dq_oe),
        .ssram_dq_in         (ssram_dq_in)
    );

    always #5 sram_clock = ~sram_clock;

    int n_tests = 0;
    int n_fail  = 0;
    int cyc     = 0;

    // SSRAM model: command in cycle C, data phase in C+2.
    logic [31:0] mem   [64];
    logic        wrote [64];
    logic        m_rd1, m_rd2, m_wr1, m_wr2;
    logic [5:0]  m_a1, m_a2;
    logic [3:0]  m_bw1, m_bw2;

    always @(posedge sram_clock) begin
        cyc <= cyc + 1;
        if (!reset_n) begin
            m_rd1 <= 1'b0; m_rd2 <= 1'b0; m_wr1 <= 1'b0; m_wr2 <= 1'b0;
            for (int i = 0; i < 64; i++) wrote[i] <= 1'b0;
        end else begin
            m_rd1 <= !ssram_ce_b && ssram_we_b;
            m_wr1 <= !ssram_ce_b && !ssram_we_b;
            m_a1  <= ssram_addr[5:0];
            m_bw1 <= ssram_bw_b;
            m_rd2 <= m_rd1;
            m_wr2 <= m_wr1;
            m_a2  <= m_a1;
            m_bw2 <= m_bw1;
            if (m_wr2 && ssram_dq_oe) begin
                if (!wrote[m_a2]) mem[m_a2] <= 32'h100 + 32'(m_a2);
                wrote[m_a2] <= 1'b1;
                for (int b = 0; b < 4; b++)
                    if (!m_bw2[b]) mem[m_a2][8*b +: 8] <= ssram_dq_out[8*b +: 8];
            end
        end
    end

    assign ssram_dq_in = !m_rd2 ? 32'h0 : (wrote[m_a2] ? mem[m_a2] : 32'h100 + 32'(m_a2));

    // Read-strobe and pad-enable history.
    int          got_cyc [$];
    logic [31:0] got_dat [$];
    int          exp_cyc [$];
    logic [31:0] exp_dat [$];
    logic        oe_log [1024];
    logic [31:0] dq_log [1024];

    always @(negedge sram_clock) begin
        if (sram_data_out_valid) begin
            got_cyc.push_back(cyc);
            got_dat.push_back(sram_data_out);
        end
        oe_log[cyc % 1024] = ssram_dq_oe;
        dq_log[cyc % 1024] = ssram_dq_out;
    end

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic step_cyc();
        @(negedge sram_clock);
    endtask

    task automatic idle(input int k);
        sram_addr_valid = 1'b0;
        repeat (k) step_cyc();
    endtask

    task automatic issue(input logic [18:0] a, input logic [31:0] d, input logic [3:0] m,
                         input logic [31:0] exp_rd);
        sram_addr_valid = 1'b1;
        sram_addr       = a;
        sram_data_in    = d;
        sram_write_mask = m;
        if (m == 4'b0000) begin
            exp_cyc.push_back(cyc + 4);
            exp_dat.push_back(exp_rd);
        end
        step_cyc();
    endtask

    task automatic wait_init(output int n, output bit cmd);
        n = 0;
        cmd = 1'b0;
        while (!sram_ready && n < 40) begin
            if (!ssram_ce_b) cmd = 1'b1;
            n++;
            step_cyc();
        end
    endtask

    task automatic check_reset_vals(input string tag);
        chk({tag, "_ready"},   64'(sram_ready), 64'(0));
        chk({tag, "_dvld"},    64'(sram_data_out_valid), 64'(0));
        chk({tag, "_dout"},    64'(sram_data_out), 64'(0));
        chk({tag, "_ce_b"},    64'(ssram_ce_b), 64'(1));
        chk({tag, "_we_b"},    64'(ssram_we_b), 64'(1));
        chk({tag, "_adv_ld_b"}, 64'(ssram_adv_ld_b), 64'(1));
        chk({tag, "_bw_b"},    64'(ssram_bw_b), 64'(4'b1111));
        chk({tag, "_addr"},    64'(ssram_addr), 64'(0));
        chk({tag, "_dq_out"},  64'(ssram_dq_out), 64'(0));
        chk({tag, "_dq_oe"},   64'(ssram_dq_oe), 64'(0));
    endtask

    task automatic check_reads(input string tag);
        chk({tag, "_count"}, 64'(got_cyc.size()), 64'(exp_cyc.size()));
        for (int i = 0; i < exp_cyc.size() && i < got_cyc.size(); i++) begin
            chk($sformatf("%s_cyc%0d", tag, i), 64'(got_cyc[i]), 64'(exp_cyc[i]));
            chk($sformatf("%s_dat%0d", tag, i), 64'(got_dat[i]), 64'(exp_dat[i]));
        end
        got_cyc.delete(); got_dat.delete();
        exp_cyc.delete(); exp_dat.delete();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        int n;
        bit cmd;
        int base;

        repeat (3) step_cyc();
        check_reset_vals("rst");

        // Release reset with a read to addr 5 already pending.
        sram_addr_valid = 1'b1;
        sram_addr       = 19'h5;
        sram_write_mask = 4'b0000;
        reset_n         = 1'b1;
        wait_init(n, cmd);
        chk("init_len", 64'(n), 64'(16));
        chk("init_no_cmd", 64'(cmd), 64'(0));
        chk("init_idle_ce", 64'(ssram_ce_b), 64'(1));
        exp_cyc.push_back(cyc + 4);
        exp_dat.push_back(32'h105);
        step_cyc();
        chk("first_ce", 64'(ssram_ce_b), 64'(0));
        chk("first_adv", 64'(ssram_adv_ld_b), 64'(0));
        chk("first_we", 64'(ssram_we_b), 64'(1));
        chk("first_addr", 64'(ssram_addr), 64'(5));
        idle(6);
        check_reads("first_rd");

        // Full-rate reads.
        for (int i = 0; i < 64; i++) issue(19'(i), 32'h0, 4'b0000, 32'h100 + 32'(i));
        idle(8);
        check_reads("b2b");

        // Full-word write.
        issue(19'h10, 32'hDEADBEEF, 4'b1111, 32'h0);
        chk("wr_ce", 64'(ssram_ce_b), 64'(0));
        chk("wr_we", 64'(ssram_we_b), 64'(0));
        chk("wr_bw", 64'(ssram_bw_b), 64'(4'b0000));
        chk("wr_addr", 64'(ssram_addr), 64'(19'h10));
        sram_addr_valid = 1'b0;
        step_cyc();
        chk("wr_oe_n2", 64'(ssram_dq_oe), 64'(0));
        step_cyc();
        chk("wr_oe_n3", 64'(ssram_dq_oe), 64'(1));
        chk("wr_dq_n3", 64'(ssram_dq_out), 64'(32'hDEADBEEF));
        step_cyc();
        chk("wr_oe_n4", 64'(ssram_dq_oe), 64'(0));
        chk("idle_ce", 64'(ssram_ce_b), 64'(1));
        chk("idle_we", 64'(ssram_we_b), 64'(1));
        chk("idle_bw", 64'(ssram_bw_b), 64'(4'b1111));
        chk("idle_addr_hold", 64'(ssram_addr), 64'(19'h10));
        idle(2);

        // Read it back.
        issue(19'h10, 32'h0, 4'b0000, 32'hDEADBEEF);
        chk("rd_we", 64'(ssram_we_b), 64'(1));
        chk("rd_bw", 64'(ssram_bw_b), 64'(4'b1111));
        sram_addr_valid = 1'b0;
        step_cyc();
        step_cyc();
        chk("rd_oe_n3", 64'(ssram_dq_oe), 64'(0));
        idle(4);
        check_reads("rd_beef");
        chk("rd_hold_dat", 64'(sram_data_out), 64'(32'hDEADBEEF));
        chk("rd_hold_vld", 64'(sram_data_out_valid), 64'(0));

        // Alternating W/R/W/R with a half-word mask.
        base = cyc;
        for (int k = 0; k < 4; k++) begin
            issue(19'(k), 32'h11 * 32'(k + 1), (k % 2 == 0) ? 4'b0011 : 4'b0000,
                  32'h100 + 32'(k));
            chk($sformatf("alt_bw%0d", k), 64'(ssram_bw_b),
                64'((k % 2 == 0) ? 4'b1100 : 4'b1111));
            chk($sformatf("alt_we%0d", k), 64'(ssram_we_b), 64'((k % 2 == 0) ? 0 : 1));
        end
        idle(6);
        check_reads("alt");
        for (int k = 0; k < 4; k++) begin
            chk($sformatf("alt_oe%0d", k), 64'(oe_log[(base + k + 3) % 1024]),
                64'((k % 2 == 0) ? 1 : 0));
            if (k % 2 == 0)
                chk($sformatf("alt_dq%0d", k), 64'(dq_log[(base + k + 3) % 1024]),
                    64'(32'h11 * 32'(k + 1)));
        end

        // Reset with two reads in flight.
        issue(19'h4, 32'h0, 4'b0000, 32'h104);
        issue(19'h5, 32'h0, 4'b0000, 32'h105);
        sram_addr_valid = 1'b0;
        step_cyc();
        reset_n = 1'b0;
        #1;
        check_reset_vals("midrst");
        exp_cyc.delete();
        exp_dat.delete();
        step_cyc();
        step_cyc();
        reset_n = 1'b1;
        wait_init(n, cmd);
        chk("reinit_len", 64'(n), 64'(16));
        chk("reinit_no_cmd", 64'(cmd), 64'(0));
        idle(6);
        check_reads("rst_drop");

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/sram_responder.md
# sram_responder

Memory-side responder for the SRAM request interface driven by the SRAM arbiter. It accepts one request per cycle (address, data, byte write mask) on `sram_clock` and drives an external pipelined ZBT SSRAM. Read data returns in request order with a fixed latency. It sits between the arbiter and the board SSRAM pins.

## Interface
- `ADDR_WIDTH`, 19: SSRAM word address width.
- `DATA_WIDTH`, 32: data word width.
- `MASK_WIDTH`, 4: byte-enable width, `DATA_WIDTH/8`.
- `INIT_CYCLES`, 16: cycles after reset before the first request is accepted.
- `sram_clock`  in  1  sole clock; all logic on rising edge.
- `reset_n`  in  1  asynchronous, active-low reset.
- `sram_addr_valid`  in  1  request present.
- `sram_ready`  out  1  request accepted on a cycle where both are high.
- `sram_addr`  in  ADDR_WIDTH  request word address.
- `sram_data_in`  in  DATA_WIDTH  write data.
- `sram_write_mask`  in  MASK_WIDTH  bit i=1 writes byte i; all-zero = read.
- `sram_data_out`  out  DATA_WIDTH  read data.
- `sram_data_out_valid`  out  1  one-cycle strobe per completed read.
- `ssram_ce_b`, `ssram_adv_ld_b`, `ssram_we_b`  out  1 each  SSRAM controls, active-low.
- `ssram_bw_b`  out  MASK_WIDTH  byte writes, active-low.
- `ssram_addr`  out  ADDR_WIDTH  SSRAM address.
- `ssram_dq_out`  out  DATA_WIDTH  write data to pad.
- `ssram_dq_oe`  out  1  pad output enable.
- `ssram_dq_in`  in  DATA_WIDTH  data from pad.

## Operation
- FSM states INIT, RUN. Reset enters INIT, loads a counter with `INIT_CYCLES-1`; at zero moves to RUN. `sram_ready`=0 in INIT, 1 in RUN. No other exit from RUN except reset.
- Accept = `sram_addr_valid & sram_ready`. On accept (cycle N, edge at end of N): registered command pins in cycle N+1: `ssram_ce_b`=0, `ssram_adv_ld_b`=0, `ssram_addr`=`sram_addr`, `ssram_we_b`=0 if mask≠0 else 1, `ssram_bw_b`=~mask for writes, all-ones for reads.
- No accept: `ssram_ce_b`=1, `ssram_we_b`=1, `ssram_bw_b` all-ones, `ssram_adv_ld_b`=0, address holds.
- 3-stage in-flight shift pipeline carrying {valid, is_write, data}. Write: cycle N+3 drives `ssram_dq_out`=data, `ssram_dq_oe`=1. Read: `ssram_dq_in` sampled at end of N+3; `sram_data_out`/`sram_data_out_valid`=1 in cycle N+4.
- Back-to-back any mix of reads/writes at full rate; ZBT needs no turnaround, but `ssram_dq_oe` must be 0 in any cycle whose slot holds a read or nothing.
- Responses strictly in request order; no reordering, no drop.
- `sram_data_out` holds last read value when valid=0.

## Timing
- Reset values: `sram_ready`=0, `sram_data_out_valid`=0, `sram_data_out`=0, `ssram_ce_b`=1, `ssram_we_b`=1, `ssram_adv_ld_b`=1, `ssram_bw_b` all-ones, `ssram_addr`=0, `ssram_dq_out`=0, `ssram_dq_oe`=0, pipeline valids=0.
- First accept possible in cycle `INIT_CYCLES` after reset release.
- Read latency: accept cycle N to `sram_data_out_valid` in N+4, fixed. Throughput 1 request/cycle.
- Reset asserted mid-operation: in-flight requests discarded, no late `sram_data_out_valid`, pads tri-stated immediately (async), INIT repeats.
- `sram_addr_valid` while `sram_ready`=0: ignored, nothing issued.

## Structure
- Shared package: `SRAM_ADDR_WIDTH`, `SRAM_DATA_WIDTH`, `SRAM_MASK_WIDTH`, read/write decode helper (mask==0 → read), FSM state encodings.
- One sub-module: `sram_pipe_stage` (one registered {valid, is_write, data} slot, reset-clearable), instantiated three times.

## Test plan
- Reset release with `sram_addr_valid`=1 held: `sram_ready`=0 for exactly 16 cycles, no SSRAM command, then first accept.
- Write addr 0x00010, data 0xDEADBEEF, mask 4'b1111 at cycle N: N+1 `ssram_we_b`=0, `ssram_bw_b`=0000, addr 0x00010; N+3 `ssram_dq_oe`=1, `ssram_dq_out`=0xDEADBEEF.
- Read addr 0x00010 with SSRAM model returning 0xDEADBEEF: `sram_data_out_valid` exactly in N+4, `sram_data_out`=0xDEADBEEF, `ssram_dq_oe`=0 in N+3.
- Alternating W/R/W/R every cycle to addrs 0..3, data 0x11..0x44, mask 4'b0011 on writes: `ssram_bw_b`=1100 on writes; two read strobes, in order, 4 cycles after each read accept; no dq_oe on read slots.
- Assert `reset_n`=0 one cycle after two reads accepted: no `sram_data_out_valid` afterward; all outputs at reset values immediately; INIT repeats for 16 cycles.
- 64 back-to-back reads of addrs 0..63 against model returning addr+0x100: 64 strobes, consecutive cycles, data 0x100..0x13F in order.
